// File: rtl/wb_slave_responder_if.sv
// Wishbone classic-cycle bundle for wb_slave_responder; signal names are
// seen from the slave side, so the master modport drives the *_i signals.
interface wb_slave_responder_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  irq_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i,
        output dat_o, ack_o, irq_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i,
        input  dat_o, ack_o, irq_o
    );
endinterface

// File: rtl/wb_slave_responder.sv
// Wishbone classic slave: small register bank with programmable wait states.
// Define WB_SLV_IRQ_EN to turn register IRQ_ADDR into a doorbell driving irq_o.
module wb_slave_responder #(
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 0,
    parameter int IRQ_ADDR    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    wb_slave_responder_if.slave     wb
);

    localparam int              NREGS   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("wb_slave_responder: WAIT_STATES must be in 0..15");
    end
    if (IRQ_ADDR < 0 || IRQ_ADDR >= NREGS) begin : g_bad_irq_addr
        $error("wb_slave_responder: IRQ_ADDR must index the register bank");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q,   cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q,   adr_d;
    logic                    we_q,    we_d;
    logic [DATA_WIDTH-1:0]   dat_q,   dat_d;
    logic                    ack_q,   ack_d;
    logic [DATA_WIDTH-1:0]   rdat_q,  rdat_d;
    logic [DATA_WIDTH-1:0]   regs_q [NREGS];
    logic [DATA_WIDTH-1:0]   regs_d [NREGS];

    // Transaction committed on this edge (ack entry) and the values it uses.
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   c_adr;
    logic                    c_we;
    logic [DATA_WIDTH-1:0]   c_dat;
    logic                    req;

    assign req = wb.cyc_i & wb.stb_i;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        dat_d   = dat_q;
        commit  = 1'b0;
        c_adr   = adr_q;
        c_we    = we_q;
        c_dat   = dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d = wb.adr_i;
                    we_d  = wb.we_i;
                    dat_d = wb.dat_i;
                    cnt_d = WS_LOAD;
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: capture and ack entry share one edge.
                        state_d = ST_ACK;
                        commit  = 1'b1;
                        c_adr   = wb.adr_i;
                        c_we    = wb.we_i;
                        c_dat   = wb.dat_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb.cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        ack_d  = commit;
        rdat_d = '0;
        if (commit) begin
            if (c_we) begin
                regs_d[c_adr] = c_dat;
            end else begin
                rdat_d = regs_q[c_adr];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
        end
    end

    // NOTE: the bank is tiny and must read 0 after reset, so it is built from resettable flops rather than RAM.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = rdat_q;

`ifdef WB_SLV_IRQ_EN
    localparam logic [ADDR_WIDTH-1:0] IRQ_IDX = ADDR_WIDTH'(IRQ_ADDR);

    logic pend_q, pend_d;
    logic irq_q,  irq_d;

    // A doorbell write sets pending, a doorbell read clears it; irq_o lags by one cycle.
    always_comb begin
        pend_d = pend_q;
        if (commit && (c_adr == IRQ_IDX)) begin
            pend_d = c_we;
        end
        irq_d = pend_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign wb.irq_o = irq_q;
`else
    assign wb.irq_o = 1'b0;
`endif

endmodule
